if_fetch_queue: RTL and testbench

- Instruction prefetch queue between the instruction-fetch stage (PC, PC+4, instruction memory read) and the decode stage.
- Buffers fetched {pc_mais_4, instruction} pairs so fetch keeps running while decode stalls (PCWrite/IFIDWrite low).
- Discards all buffered work on a branch/jump flush (IFFlush).
- Replaces the bare IF/ID register. When empty, it presents a NOP (32'h0, sll $0,$0,0) to decode.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetchq_ram.sv | 25 ++
 rtl/if_fetch_queue.sv | 95 +++++++++
 tb/tb_if_fetch_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch/decode boundary.
// Provides the decode NOP, the datapath width and the fetch entry bundle.
package cpu_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [DATA_W-1:0] pc_plus_4;
    logic [DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetchq_ram.sv
// Fetch queue storage: DEPTH x W, one synchronous write port and one
// asynchronous read port, no reset. Ports: i_clock, i_we/i_waddr/i_wdata, i_raddr/o_rdata.
module fetchq_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     i_clock,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// Prefetch queue between fetch and decode; presents a NOP when empty.
// Ports: clock/reset/flush, in_* push side, out_* pop side, count. Macro: FETCHQ_BYPASS_EN.
module if_fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_pc_plus_4,
  input  logic [DATA_W-1:0]      in_inst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_pc_plus_4,
  output logic [DATA_W-1:0]      out_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_cnt;
  logic                w_full;
  logic                w_nonempty;
  logic                w_byp;
  logic                w_push;
  logic                w_pop;
  logic [2*DATA_W-1:0] w_rdata;

`ifdef FETCHQ_BYPASS_EN
  assign w_byp = ~w_nonempty & in_valid & out_ready & ~flush;
`else
  assign w_byp = 1'b0;
`endif

  assign w_full     = (r_cnt == CW'(DEPTH));
  assign w_nonempty = (r_cnt != '0);
  assign in_ready   = ~w_full & ~flush;
  // A bypassed entry goes straight to decode and is never stored.
  assign w_push     = in_valid & in_ready & ~w_byp;
  assign w_pop      = w_nonempty & out_ready & ~flush;
  assign out_valid  = w_nonempty | w_byp;
  assign count      = r_cnt;

  always_comb begin
    out_pc_plus_4 = '0;
    out_inst      = DATA_W'(NOP_INST);
    unique case (1'b1)
      w_byp: begin
        out_pc_plus_4 = in_pc_plus_4;
        out_inst      = in_inst;
      end
      w_nonempty: begin
        out_pc_plus_4 = w_rdata[2*DATA_W-1:DATA_W];
        out_inst      = w_rdata[DATA_W-1:0];
      end
      default: ;
    endcase
  end

  fetchq_ram #(
    .DEPTH (DEPTH),
    .W     (2 * DATA_W)
  ) u_ram (
    .i_clock (clock),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({in_pc_plus_4, in_inst}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_if_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc_plus_4;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc_plus_4;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  if_fetch_queue #(.DEPTH(4), .DATA_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc_plus_4  (in_pc_plus_4),
    .in_inst       (in_inst),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc_plus_4 (out_pc_plus_4),
    .out_inst      (out_inst),
    .count         (count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    in_valid     = 1'b1;
    in_inst      = inst;
    in_pc_plus_4 = pc;
    step();
    in_valid     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc_plus_4 = '0;
    step();
    step();
    reset = 1'b0;
    smp();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_pc", out_pc_plus_4, 32'h0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Fill with decode stalled
    step();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_inst = 32'h2008_0001 + 32'(i);
      in_pc_plus_4 = 32'(4 * (i + 1));
      smp();
      chk("fill_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b1;
    in_inst = 32'h2008_0005;
    in_pc_plus_4 = 32'h14;
    smp();
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_head", out_inst, 32'h2008_0001);
    step();
    in_valid = 1'b0;
    smp();
    chk("full_hold", 32'(count), 32'd4);

    // Drain
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_inst", out_inst, 32'h2008_0001 + 32'(i));
      chk("drain_pc", out_pc_plus_4, 32'(4 * (i + 1)));
      step();
    end
    out_ready = 1'b0;
    smp();
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_inst", out_inst, 32'h0);
    chk("empty_count", 32'(count), 32'd0);

    // Steady push/pop with pointer wrap
    step();
    push(32'h1000, 32'h2000);
    push(32'h1001, 32'h2004);
    for (int j = 0; j < 10; j++) begin
      in_valid = 1'b1;
      out_ready = 1'b1;
      in_inst = 32'h1002 + 32'(j);
      in_pc_plus_4 = 32'h2008 + 32'(4 * j);
      smp();
      chk("pp_count", 32'(count), 32'd2);
      chk("pp_inst", out_inst, 32'h1000 + 32'(j));
      chk("pp_pc", out_pc_plus_4, 32'h2000 + 32'(4 * j));
      step();
    end
    in_valid = 1'b0;
    for (int j = 10; j < 12; j++) begin
      smp();
      chk("pp_tail", out_inst, 32'h1000 + 32'(j));
      step();
    end
    out_ready = 1'b0;
    smp();
    chk("pp_empty", 32'(count), 32'd0);

    // Flush with concurrent push and pop
    step();
    for (int k = 0; k < 3; k++) push(32'h300 + 32'(k), 32'h40 + 32'(k));
    flush = 1'b1;
    in_valid = 1'b1;
    in_inst = 32'h0800_0010;
    in_pc_plus_4 = 32'h80;
    out_ready = 1'b1;
    smp();
    chk("fl_vis", 32'(out_valid), 32'd1);
    chk("fl_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    smp();
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_inst", out_inst, 32'h0);
    step();
    smp();
    chk("fl_drop", out_inst, 32'h0);
    chk("fl_drop_v", 32'(out_valid), 32'd0);

    // Reset mid-operation, then first push
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push(32'h500 + 32'(k), 32'h60 + 32'(k));
    smp();
    chk("pre_rst", 32'(count), 32'd3);
    step();
    reset = 1'b1;
    flush = 1'b1;
    in_valid = 1'b1;
    in_inst = 32'hDEAD_BEEF;
    step();
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    smp();
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_inst", out_inst, 32'h0);
    chk("mr_pc", out_pc_plus_4, 32'h0);
    chk("mr_count", 32'(count), 32'd0);

    step();
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_inst = 32'h0022_1820;
    in_pc_plus_4 = 32'h44;
    smp();
`ifdef FETCHQ_BYPASS_EN
    chk("byp_valid", 32'(out_valid), 32'd1);
    chk("byp_inst", out_inst, 32'h0022_1820);
    chk("byp_pc", out_pc_plus_4, 32'h44);
    chk("byp_count", 32'(count), 32'd0);
`else
    chk("nb_valid0", 32'(out_valid), 32'd0);
    chk("nb_inst0", out_inst, 32'h0);
`endif
    step();
    in_valid = 1'b0;
    smp();
`ifdef FETCHQ_BYPASS_EN
    chk("byp_after_v", 32'(out_valid), 32'd0);
    chk("byp_after_c", 32'(count), 32'd0);
`else
    chk("nb_valid1", 32'(out_valid), 32'd1);
    chk("nb_inst1", out_inst, 32'h0022_1820);
    chk("nb_pc1", out_pc_plus_4, 32'h44);
    chk("nb_count1", 32'(count), 32'd1);
`endif
    step();
    out_ready = 1'b0;
    smp();
    chk("end_count", 32'(count), 32'd0);
    chk("end_inst", out_inst, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
